// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance event monitor.
// Holds the FSM state type, default counter width and index-width helper.
package perf_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Width needed to address n event entries plus the cycle entry.
  function automatic int perf_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One event counter with synchronous clear and a sticky overflow flag.
// Ports: clk, rst, clr, inc in; nxt (next value, equals the held value
// when inc/clr are low) and ovf out. PERF_SAT_EN selects saturation.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] nxt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt;
  logic             full;

  assign full = &cnt;

`ifdef PERF_SAT_EN
  assign nxt = (inc && !full) ? cnt + CNT_W'(1) : cnt;
`else
  assign nxt = cnt + CNT_W'(inc);
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= nxt;
      if (inc && full)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// Event/cycle counters with a halt-triggered valid/ready dump port.
// Ports: clk, rst, en, clear, events, halt, dump_ready in; dump_valid,
// dump_idx, dump_data, dump_last, overflow, running out.
// Macro PERF_SAT_EN: counters saturate instead of wrapping.
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 5,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int IDX_W      = perf_idx_w(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  halt,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [IDX_W-1:0]      dump_idx,
  output logic [CNT_W-1:0]      dump_data,
  output logic                  dump_last,
  output logic [NUM_EVENTS:0]   overflow,
  output logic                  running
);

  localparam int NCH = NUM_EVENTS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_EVENTS);

  state_e           state;
  logic             cnt_en;
  logic [NCH-1:0]   inc;
  logic [CNT_W-1:0] nxt [NCH];
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] sel_data;

  // en qualifies every counting edge, so the edge that leaves IDLE
  // on en and the halt edge are both counted.
  assign cnt_en = en && !clear &&
                  (state == ST_IDLE || state == ST_RUN);
  assign inc    = {1'b1, events} & {NCH{cnt_en}};

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (inc[g]),
      .nxt (nxt[g]),
      .ovf (overflow[g])
    );
  end

  // Entry 0 is loaded on the halt edge, so it must see that
  // edge's increment; nxt is used for every entry for that reason.
  always_comb begin
    sel_idx  = (state == ST_DUMP) ? dump_idx + IDX_W'(1) : '0;
    sel_data = '0;
    for (int i = 0; i < NCH; i++)
      if (sel_idx == IDX_W'(i))
        sel_data = nxt[i];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= ST_IDLE;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_RUN: begin
          if (halt) begin
            state     <= ST_DUMP;
            dump_idx  <= '0;
            dump_data <= sel_data;
          end else begin
            state <= en ? ST_RUN : ST_IDLE;
          end
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              dump_idx  <= dump_idx + IDX_W'(1);
              dump_data <= sel_data;
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dump_valid = (state == ST_DUMP);
  assign dump_last  = dump_valid && (dump_idx == LAST_IDX);
  assign running    = (state == ST_RUN);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench for perf_event_monitor: per-cycle model compare
// plus literal checks of dumped entries. Honours PERF_SAT_EN.
module tb_perf_event_monitor;

  localparam int N  = 5;
  localparam int W  = 32;
  localparam int SW = 4;
  localparam longint MAXV = (longint'(1) << W) - 1;
  localparam int P_IDLE = 0, P_RUN = 1, P_DUMP = 2, P_DONE = 3;

  logic         clk = 1'b0;
  logic         rst, en, clear, halt, dump_ready;
  logic [N-1:0] events;
  logic         dump_valid, dump_last, running;
  logic [2:0]   dump_idx;
  logic [W-1:0] dump_data;
  logic [N:0]   overflow;

  logic          s_en, s_halt, s_ready;
  logic [N-1:0]  s_events;
  logic          s_valid, s_last, s_running;
  logic [2:0]    s_idx;
  logic [SW-1:0] s_data;
  logic [N:0]    s_ovf;

  int vectors = 0;
  int miscompares = 0;

  perf_event_monitor #(.NUM_EVENTS(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .events(events), .halt(halt),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .overflow(overflow),
    .running(running)
  );

  perf_event_monitor #(.NUM_EVENTS(N), .CNT_W(SW)) u_small (
    .clk(clk), .rst(rst), .en(s_en), .clear(1'b0),
    .events(s_events), .halt(s_halt),
    .dump_valid(s_valid), .dump_ready(s_ready),
    .dump_idx(s_idx), .dump_data(s_data),
    .dump_last(s_last), .overflow(s_ovf),
    .running(s_running)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  longint       m_cnt [N+1] = '{default: 0};
  int           phase = P_IDLE;
  logic [W-1:0] ent_q [$];
  int           e_idx = 0;
  logic [W-1:0] e_data = '0;

  function automatic logic [W-1:0] value_of(longint c);
`ifdef PERF_SAT_EN
    return (c > MAXV) ? W'(MAXV) : W'(c);
`else
    return W'(c);
`endif
  endfunction

  always @(posedge clk) begin
    if (rst || clear) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      phase = P_IDLE;
      ent_q.delete();
      e_idx = 0;
      e_data = '0;
    end else if (phase == P_IDLE || phase == P_RUN) begin
      if (en) begin
        for (int i = 0; i < N; i++)
          m_cnt[i] += longint'(events[i]);
        m_cnt[N] += 1;
      end
      if (halt) begin
        phase = P_DUMP;
        ent_q.delete();
        for (int i = 0; i <= N; i++)
          ent_q.push_back(value_of(m_cnt[i]));
        e_idx = 0;
        e_data = ent_q[0];
      end else begin
        phase = en ? P_RUN : P_IDLE;
      end
    end else if (phase == P_DUMP && dump_ready) begin
      void'(ent_q.pop_front());
      if (ent_q.size() == 0) begin
        phase = P_DONE;
      end else begin
        e_idx++;
        e_data = ent_q[0];
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    chk(nm, act, exp);
  endtask

  always @(negedge clk) begin
    logic [N:0] eo;
    logic       ev;
    for (int i = 0; i <= N; i++)
      eo[i] = (m_cnt[i] > MAXV);
    ev = (phase == P_DUMP);
    vectors++;
    chk("dump_valid", 64'(dump_valid), 64'(ev));
    chk("dump_idx",   64'(dump_idx),   64'(e_idx));
    chk("dump_data",  64'(dump_data),  64'(e_data));
    chk("dump_last",  64'(dump_last),  64'(ev && e_idx == N));
    chk("overflow",   64'(overflow),   64'(eo));
    chk("running",    64'(running),    64'(phase == P_RUN));
  end

  // ---------------- capture ----------------
  logic [W-1:0]  got_q [$];
  int            last_seen = -1;
  logic [SW-1:0] s_got [N+1];
  int            s_got_n = 0;

  always @(negedge clk) begin
    if (dump_valid && dump_ready) begin
      got_q.push_back(dump_data);
      if (dump_last) last_seen = int'(dump_idx);
    end
    if (s_valid && s_ready) begin
      s_got[s_idx] = s_data;
      s_got_n++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dump();
    for (int k = 0; k < 40 && got_q.size() < N + 1; k++) step();
    lit("dump_entries", 64'(got_q.size()), 64'(N + 1));
  endtask

  task automatic chk_entries(string nm, longint exp [N+1]);
    for (int i = 0; i <= N; i++)
      lit(nm, (i < got_q.size()) ? 64'(got_q[i]) : '1, 64'(exp[i]));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    got_q.delete();
  endtask

  initial begin
    logic [0:4] en_seq;
    longint     e1 [N+1];
    longint     z [N+1];
    rst = 1'b1; en = 1'b0; clear = 1'b0; halt = 1'b0;
    events = '0; dump_ready = 1'b1;
    s_en = 1'b0; s_halt = 1'b0; s_ready = 1'b1; s_events = '0;
    z = '{0, 0, 0, 0, 0, 0};
    step(); step();
    rst = 1'b0;
    lit("reset_valid", 64'(dump_valid), 0);
    lit("reset_ovf", 64'(overflow), 0);

    // Ten enabled cycles of 5'b00101, halt on the tenth.
    got_q.delete();
    en = 1'b1; events = 5'b00101;
    for (int k = 1; k <= 10; k++) begin
      halt = (k == 10);
      step();
    end
    en = 1'b0; events = '0; halt = 1'b0;
    wait_dump();
    e1 = '{10, 0, 10, 0, 0, 10};
    chk_entries("t1_entry", e1);
    lit("t1_last_idx", 64'(last_seen), 64'(N));
    step(); step();
    lit("t1_done_valid", 64'(dump_valid), 0);

    // en toggled 1,1,0,0,1 then halt with en.
    do_clear();
    en_seq = 5'b11001;
    events = 5'b00001;
    for (int k = 0; k < 5; k++) begin
      en = en_seq[k];
      step();
    end
    en = 1'b1; halt = 1'b1;
    step();
    en = 1'b0; halt = 1'b0; events = '0;
    wait_dump();
    e1 = '{4, 0, 0, 0, 0, 4};
    chk_entries("t2_entry", e1);

    // Mixed patterns, back-pressure on entry 2.
    do_clear();
    en = 1'b1;
    events = 5'b11010;
    repeat (3) step();
    events = 5'b01111;
    repeat (2) step();
    events = 5'b10000; halt = 1'b1;
    step();
    en = 1'b0; halt = 1'b0; events = '0;
    for (int k = 0; k < 40 && got_q.size() < N + 1; k++) begin
      dump_ready = !(k >= 2 && k < 5);
      step();
    end
    dump_ready = 1'b1;
    lit("t3_entries", 64'(got_q.size()), 64'(N + 1));
    e1 = '{2, 5, 2, 5, 4, 6};
    chk_entries("t3_entry", e1);
    lit("t3_done_valid", 64'(dump_valid), 0);

    // clear mid-dump at idx 3; events in the clear cycle are dropped.
    do_clear();
    en = 1'b1; events = 5'b11111;
    for (int k = 1; k <= 4; k++) begin
      halt = (k == 4);
      step();
    end
    en = 1'b0; events = '0; halt = 1'b0;
    for (int k = 0; k < 20 && !(dump_valid && dump_idx == 3); k++)
      step();
    lit("t5_idx3", 64'(dump_idx), 3);
    clear = 1'b1; en = 1'b1; events = 5'b11111;
    step();
    clear = 1'b0; en = 1'b0; events = '0;
    lit("t5_valid", 64'(dump_valid), 0);
    lit("t5_running", 64'(running), 0);
    lit("t5_ovf", 64'(overflow), 0);
    got_q.delete();
    halt = 1'b1;
    step();
    halt = 1'b0;
    wait_dump();
    chk_entries("t5_zero", z);

    // halt in IDLE right after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    got_q.delete();
    halt = 1'b1;
    step();
    halt = 1'b0;
    wait_dump();
    chk_entries("t6_zero", z);

    // 4-bit counters: 17 increments of events[1].
    s_en = 1'b1; s_events = 5'b00010;
    for (int k = 1; k <= 17; k++) begin
      s_halt = (k == 17);
      step();
    end
    s_en = 1'b0; s_halt = 1'b0; s_events = '0;
    for (int k = 0; k < 40 && s_got_n < N + 1; k++) step();
    lit("s_entries", 64'(s_got_n), 64'(N + 1));
`ifdef PERF_SAT_EN
    lit("s_cnt1", 64'(s_got[1]), 15);
    lit("s_cyc", 64'(s_got[5]), 15);
`else
    lit("s_cnt1", 64'(s_got[1]), 1);
    lit("s_cyc", 64'(s_got[5]), 1);
`endif
    lit("s_cnt0", 64'(s_got[0]), 0);
    lit("s_ovf", 64'(s_ovf), 64'(6'b100010));
    lit("s_done", 64'(s_valid), 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
